// File: rtl/adc_scan_avg.sv
// Round-robin channel scanner and per-channel averager sitting behind the LTC2308 serial interface.
// Accounts for the ADC's one-frame channel pipeline and keeps a register file of the latest averages.
module adc_scan_avg #(
  parameter int NUM_CH   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        adc_valid,
  input  logic [11:0] adc_result,
  output logic [2:0]  chan,
  output logic        out_valid,
  output logic [2:0]  out_chan,
  output logic [11:0] out_data,
  input  logic [2:0]  rd_chan,
  output logic [11:0] rd_data
);

  localparam int            AW         = 12 + AVG_LOG2;
  localparam int            SW         = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SW-1:0] SWEEP_LAST = SW'((1 << AVG_LOG2) - 1);
  localparam logic [2:0]    LAST_CH    = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t        state, state_next;
  logic [2:0]    rc;
  logic [SW-1:0] sweep;
  logic [AW-1:0] acc     [8];
  logic [11:0]   avg_reg [8];

  logic [2:0]    chan_next;
  logic [AW-1:0] sum;
  logic [11:0]   avg;
  logic          sweep_done;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = PRIME;
        PRIME:   if (adc_valid) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    chan_next  = (chan == LAST_CH) ? '0 : chan + 3'd1;
    sum        = acc[rc] + AW'(adc_result);
    avg        = 12'(sum >> AVG_LOG2);
    sweep_done = (sweep == SWEEP_LAST);
  end

  // Arrays are sized for the full 3-bit channel space; entries at or above NUM_CH are never written.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chan      <= '0;
      rc        <= '0;
      sweep     <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
      rd_data   <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        acc[i]     <= '0;
        avg_reg[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      rd_data   <= ({29'd0, rd_chan} < 32'(NUM_CH)) ? avg_reg[rd_chan] : '0;

      if (!enable || state == IDLE) begin
        chan  <= '0;
        rc    <= '0;
        sweep <= '0;
        for (int unsigned i = 0; i < 8; i++) acc[i] <= '0;
      end else if (adc_valid) begin
        // In PRIME chan is still 0, so this also sets rc=0 and chan=1 mod NUM_CH for the discarded sample.
        rc   <= chan;
        chan <= chan_next;
        if (state == RUN) begin
          if (rc == LAST_CH) sweep <= sweep_done ? '0 : sweep + 1'b1;
          if (sweep_done) begin
            acc[rc]     <= '0;
            avg_reg[rc] <= avg;
            out_valid   <= 1'b1;
            out_chan    <= rc;
            out_data    <= avg;
          end else begin
            acc[rc] <= sum;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_avg.sv
// Self-checking bench for adc_scan_avg: four parameterisations share one stimulus stream and are
// compared against a sample-counting reference model.
`timescale 1ns/1ps
module tb_adc_scan_avg;

  localparam int NI = 4;
  localparam int NC [NI] = '{4, 2, 4, 1};
  localparam int LG [NI] = '{0, 2, 1, 2};

  logic        clk = 1'b0;
  logic        reset_n, enable, adc_valid;
  logic [11:0] adc_result;
  logic [2:0]  rd_chan;

  logic [NI-1:0]        ov_o;
  logic [NI-1:0][2:0]   chan_o, oc_o;
  logic [NI-1:0][11:0]  od_o, rd_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 4 : 1;
    localparam int L = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 1 : 2;
    adc_scan_avg #(.NUM_CH(N), .AVG_LOG2(L)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .adc_valid (adc_valid),
      .adc_result(adc_result),
      .chan      (chan_o[g]),
      .out_valid (ov_o[g]),
      .out_chan  (oc_o[g]),
      .out_data  (od_o[g]),
      .rd_chan   (rd_chan),
      .rd_data   (rd_o[g])
    );
  end

  // Reference model: counts samples since priming; channel and sweep follow from the count.
  int          m_mode [NI];   // 0 idle, 1 awaiting the discarded sample, 2 scanning
  int          m_k    [NI];
  int          m_sum  [NI][8];
  logic [11:0] m_avg  [NI][8];
  logic        m_ov   [NI];
  logic [2:0]  m_oc   [NI];
  logic [11:0] m_od   [NI];
  logic [11:0] m_rd   [NI];
  logic [2:0]  m_chan [NI];

  always @(posedge clk) begin : model
    int ch, sw, a;
    for (int i = 0; i < NI; i++) begin
      m_ov[i] = 1'b0;
      if (!reset_n) begin
        m_mode[i] = 0; m_k[i] = 0;
        m_oc[i] = '0; m_od[i] = '0; m_rd[i] = '0;
        for (int c = 0; c < 8; c++) begin m_sum[i][c] = 0; m_avg[i][c] = '0; end
      end else begin
        m_rd[i] = (int'(rd_chan) < NC[i]) ? m_avg[i][rd_chan] : 12'd0;
        if (!enable) begin
          m_mode[i] = 0; m_k[i] = 0;
          for (int c = 0; c < 8; c++) m_sum[i][c] = 0;
        end else if (m_mode[i] == 0) begin
          m_mode[i] = 1;
        end else if (adc_valid) begin
          if (m_mode[i] == 1) begin
            m_mode[i] = 2; m_k[i] = 0;
          end else begin
            ch = m_k[i] % NC[i];
            sw = (m_k[i] / NC[i]) % (1 << LG[i]);
            if (sw == (1 << LG[i]) - 1) begin
              a = (m_sum[i][ch] + int'(adc_result)) >> LG[i];
              m_sum[i][ch] = 0;
              m_avg[i][ch] = 12'(a);
              m_ov[i] = 1'b1; m_oc[i] = 3'(ch); m_od[i] = 12'(a);
            end else begin
              m_sum[i][ch] = m_sum[i][ch] + int'(adc_result);
            end
            m_k[i] = m_k[i] + 1;
          end
        end
      end
      m_chan[i] = (m_mode[i] == 2) ? 3'((m_k[i] + 1) % NC[i]) : 3'd0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rescan();
    adc_valid = 1'b0; enable = 1'b0; tick();
    enable = 1'b1; tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; adc_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1; adc_valid = 1'b1; adc_result = 12'hABC;
    tick();
    adc_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      rd_chan = 3'(t % 8);
      tick();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (chan_o[i] !== 3'd0 || ov_o[i] !== 1'b0 || oc_o[i] !== 3'd0 || od_o[i] !== 12'd0) begin
          n_bad++;
          $display("FAIL reset_idle dut%0d t%0d: chan=%0d ov=%b oc=%0d od=%h, want 0/0/0/000",
                   i, t, chan_o[i], ov_o[i], oc_o[i], od_o[i]);
        end
        n_cmp++;
        if (rd_o[i] !== 12'd0) begin
          n_bad++;
          $display("FAIL reset_rd dut%0d t%0d: rd_data=%h, want 000", i, t, rd_o[i]);
        end
      end
    end
  endtask

  task automatic test_prime_pipeline();
    rescan();
    for (int j = 0; j < 5; j++) begin
      adc_valid = 1'b1;
      adc_result = (j == 0) ? 12'h111 : 12'(j * 256);
      tick();
      adc_valid = 1'b0;
      n_cmp++;
      if (chan_o[0] !== 3'((j + 1) % 4)) begin
        n_bad++;
        $display("FAIL prime_chan j%0d: chan=%0d, want %0d", j, chan_o[0], (j + 1) % 4);
      end
      n_cmp++;
      if (ov_o[0] !== (j > 0)) begin
        n_bad++;
        $display("FAIL prime_ov j%0d: out_valid=%b, want %b", j, ov_o[0], (j > 0));
      end
      if (j > 0) begin
        n_cmp++;
        if (oc_o[0] !== 3'(j - 1) || od_o[0] !== 12'(j * 256)) begin
          n_bad++;
          $display("FAIL prime_out j%0d: ch%0d/%h, want ch%0d/%h", j, oc_o[0], od_o[0], j - 1, j * 256);
        end
      end
      for (int i = 1; i < NI; i++) begin
        n_cmp++;
        if (ov_o[i] !== m_ov[i] || chan_o[i] !== m_chan[i]) begin
          n_bad++;
          $display("FAIL prime_model dut%0d j%0d: ov=%b chan=%0d, want ov=%b chan=%0d",
                   i, j, ov_o[i], chan_o[i], m_ov[i], m_chan[i]);
        end
      end
      tick();
      n_cmp++;
      if (ov_o[0] !== 1'b0 || chan_o[0] !== 3'((j + 1) % 4)) begin
        n_bad++;
        $display("FAIL prime_hold j%0d: ov=%b chan=%0d, want ov=0 chan=%0d", j, ov_o[0], chan_o[0], (j + 1) % 4);
      end
    end
  endtask

  task automatic test_averaging_back_to_back();
    rescan();
    adc_valid = 1'b1; adc_result = 12'($urandom);
    tick();
    for (int j = 0; j < 8; j++) begin
      adc_result = (j % 2 == 1) ? 12'd4095 : ((j / 2 == 3) ? 12'd14 : 12'(10 + j / 2));
      tick();
      n_cmp++;
      if (ov_o[1] !== (j >= 6)) begin
        n_bad++;
        $display("FAIL avg_ov j%0d: out_valid=%b, want %b", j, ov_o[1], (j >= 6));
      end
      if (j >= 6) begin
        n_cmp++;
        if (oc_o[1] !== 3'(j - 6) || od_o[1] !== ((j == 6) ? 12'd11 : 12'd4095)) begin
          n_bad++;
          $display("FAIL avg_out j%0d: ch%0d/%0d, want ch%0d/%0d", j, oc_o[1], od_o[1], j - 6, (j == 6) ? 11 : 4095);
        end
      end
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (ov_o[i] !== m_ov[i] || oc_o[i] !== m_oc[i] || od_o[i] !== m_od[i]) begin
          n_bad++;
          $display("FAIL avg_model dut%0d j%0d: %b/%0d/%h, want %b/%0d/%h",
                   i, j, ov_o[i], oc_o[i], od_o[i], m_ov[i], m_oc[i], m_od[i]);
        end
      end
    end
    adc_valid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rd_chan = (r == 2) ? 3'd3 : 3'(r);
      tick();
      n_cmp++;
      if (rd_o[1] !== ((r == 0) ? 12'd11 : (r == 1) ? 12'd4095 : 12'd0)) begin
        n_bad++;
        $display("FAIL avg_rd rd_chan%0d: rd_data=%0d, want %0d", rd_chan, rd_o[1],
                 (r == 0) ? 11 : (r == 1) ? 4095 : 0);
      end
    end
  endtask

  task automatic test_disable_mid_sweep();
    int pubs = 0;
    rescan();
    adc_valid = 1'b1; adc_result = 12'($urandom);
    tick();
    for (int j = 0; j < 3; j++) begin adc_result = 12'($urandom); tick(); end
    enable = 1'b0; adc_result = 12'hFFF;
    tick();
    n_cmp++;
    if (chan_o[2] !== 3'd0 || ov_o[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL dis_idle: chan=%0d ov=%b, want 0/0", chan_o[2], ov_o[2]);
    end
    adc_valid = 1'b0; enable = 1'b1;
    tick();
    adc_valid = 1'b1; adc_result = 12'hFFF;
    tick();
    for (int j = 0; j < 12; j++) begin
      adc_valid = (j < 8) ? 1'b1 : 1'b0;
      adc_result = 12'($urandom);
      rd_chan = 3'(j % 4);
      tick();
      if (ov_o[2]) pubs++;
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (ov_o[i] !== m_ov[i] || oc_o[i] !== m_oc[i] || od_o[i] !== m_od[i] || chan_o[i] !== m_chan[i]) begin
          n_bad++;
          $display("FAIL dis_model dut%0d j%0d: %b/%0d/%h chan%0d, want %b/%0d/%h chan%0d", i, j,
                   ov_o[i], oc_o[i], od_o[i], chan_o[i], m_ov[i], m_oc[i], m_od[i], m_chan[i]);
        end
        n_cmp++;
        if (rd_o[i] !== m_rd[i]) begin
          n_bad++;
          $display("FAIL dis_rd dut%0d j%0d: rd_data=%h, want %h", i, j, rd_o[i], m_rd[i]);
        end
      end
    end
    n_cmp++;
    if (pubs != 4) begin
      n_bad++;
      $display("FAIL dis_pub_count: got %0d publishes, want 4", pubs);
    end
  endtask

  task automatic test_collision();
    rescan();
    adc_valid = 1'b1; adc_result = 12'($urandom);
    rd_chan = 3'd0;
    tick();
    for (int j = 0; j < 7; j++) begin
      adc_result = (j == 2) ? 12'h050 : (j == 6) ? 12'h060 : 12'($urandom);
      rd_chan = (j == 6) ? 3'd2 : 3'd0;
      tick();
    end
    n_cmp++;
    if (rd_o[0] !== 12'h050 || ov_o[0] !== 1'b1 || od_o[0] !== 12'h060) begin
      n_bad++;
      $display("FAIL coll_old: rd=%h ov=%b od=%h, want rd=050 ov=1 od=060", rd_o[0], ov_o[0], od_o[0]);
    end
    adc_valid = 1'b0;
    tick();
    n_cmp++;
    if (rd_o[0] !== 12'h060) begin
      n_bad++;
      $display("FAIL coll_new: rd_data=%h, want 060", rd_o[0]);
    end
    for (int i = 1; i < NI; i++) begin
      n_cmp++;
      if (rd_o[i] !== m_rd[i]) begin
        n_bad++;
        $display("FAIL coll_model dut%0d: rd_data=%h, want %h", i, rd_o[i], m_rd[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    rescan();
    adc_valid = 1'b1; adc_result = 12'($urandom);
    tick();
    for (int j = 0; j < 5; j++) begin adc_result = 12'($urandom_range(1, 4095)); tick(); end
    reset_n = 1'b0;
    adc_result = 12'hFFF;
    tick();
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (ov_o[i] !== 1'b0 || chan_o[i] !== 3'd0 || oc_o[i] !== 3'd0 || od_o[i] !== 12'd0 || rd_o[i] !== 12'd0) begin
        n_bad++;
        $display("FAIL rstmid dut%0d: ov=%b chan=%0d oc=%0d od=%h rd=%h, want all 0",
                 i, ov_o[i], chan_o[i], oc_o[i], od_o[i], rd_o[i]);
      end
    end
    adc_valid = 1'b0; enable = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int r = 0; r < 9; r++) begin
      rd_chan = 3'(r % 8);
      tick();
      if (r > 0) begin
        for (int i = 0; i < NI; i++) begin
          n_cmp++;
          if (rd_o[i] !== 12'd0) begin
            n_bad++;
            $display("FAIL rstmid_rd dut%0d entry%0d: rd_data=%h, want 000", i, r - 1, rd_o[i]);
          end
        end
      end
    end
  endtask

  task automatic test_random_back_to_back();
    rescan();
    for (int t = 0; t < 400; t++) begin
      enable     = ($urandom_range(0, 39) != 0);
      adc_valid  = ($urandom_range(0, 2) != 0);
      adc_result = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
      rd_chan    = 3'($urandom);
      tick();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (chan_o[i] !== m_chan[i]) begin
          n_bad++;
          $display("FAIL rnd_chan dut%0d t%0d: chan=%0d, want %0d", i, t, chan_o[i], m_chan[i]);
        end
        n_cmp++;
        if (ov_o[i] !== m_ov[i] || oc_o[i] !== m_oc[i] || od_o[i] !== m_od[i]) begin
          n_bad++;
          $display("FAIL rnd_out dut%0d t%0d: %b/%0d/%h, want %b/%0d/%h",
                   i, t, ov_o[i], oc_o[i], od_o[i], m_ov[i], m_oc[i], m_od[i]);
        end
        n_cmp++;
        if (rd_o[i] !== m_rd[i]) begin
          n_bad++;
          $display("FAIL rnd_rd dut%0d t%0d: rd_data=%h, want %h", i, t, rd_o[i], m_rd[i]);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_result = '0; rd_chan = '0;
    test_reset();
    test_prime_pipeline();
    test_averaging_back_to_back();
    test_disable_mid_sweep();
    test_collision();
    test_reset_mid();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
